mem_sequencer: RTL and testbench

MEM_SEQUENCER -- requirements
Module: mem_sequencer

---
 rtl/memsys_pkg.sv | 18 +
 rtl/mem_sequencer_rr_arb2.sv | 13 +
 rtl/mem_sequencer.sv | 149 ++++++++++++++
 tb/tb_mem_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memsys_pkg.sv
// Shared memory-system types: sequencer FSM states and load/store operation codes.
package memsys_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } seq_state_t;

    typedef enum logic {
        MEM_OP_LOAD  = 1'b0,
        MEM_OP_STORE = 1'b1
    } mem_op_t;

    localparam int unsigned WAIT_W = 10;

endpackage

// File: rtl/mem_sequencer_rr_arb2.sv
// Two-way round-robin arbiter: on a tie, the requester not granted last wins.
module rr_arb2 (
    input  logic req_a,
    input  logic req_b,
    input  logic last_b,
    output logic gnt_valid,
    output logic gnt_b
);

    assign gnt_valid = req_a | req_b;
    assign gnt_b     = req_b & (~req_a | ~last_b);

endmodule

// File: rtl/mem_sequencer.sv
// Single-port memory sequencer arbitrating fetch and data accesses; stores are
// performed as read-modify-write with the merge done externally by the LSU.
module mem_sequencer
    import memsys_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    output logic [31:0] d_rdata,
    input  logic [31:0] d_wdata,
    input  logic        d_fault,
    output logic        d_ready,
    output logic        d_err,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack
);

    localparam logic [WAIT_W-1:0] TIMEOUT = WAIT_W'(ACK_TIMEOUT);

    seq_state_t        state, state_next;
    mem_op_t           op;
    logic              sel_d;
    logic              last_d;
    logic [31:2]       addr_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              err_q;

    logic arb_valid, arb_d;
    logic grant, cnt_clr, cnt_inc, err_set, rd_latch;
    logic timed_out;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

    rr_arb2 u_arb (
        .req_a     (if_req),
        .req_b     (d_req),
        .last_b    (last_d),
        .gnt_valid (arb_valid),
        .gnt_b     (arb_d)
    );

    assign timed_out = (wait_cnt == TIMEOUT);

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        err_set    = 1'b0;
        rd_latch   = 1'b0;
        m_req      = 1'b0;
        m_we       = 1'b0;
        m_wdata    = '0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    grant      = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = RD;
                end
            end
            RD: begin
                if (timed_out) begin
                    err_set    = 1'b1;
                    state_next = RSP;
                end else begin
                    m_req = 1'b1;
                    if (m_ack) begin
                        rd_latch = 1'b1;
                        if (sel_d && op == MEM_OP_STORE) begin
                            cnt_clr    = 1'b1;
                            state_next = WR;
                        end else begin
                            // a load's misalignment fault is taken at read completion
                            err_set    = sel_d & d_fault;
                            state_next = RSP;
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            WR: begin
                // wait_cnt == 0 marks the first WR cycle, where the fault is sampled
                if (timed_out || (wait_cnt == '0 && d_fault)) begin
                    err_set    = 1'b1;
                    state_next = RSP;
                end else begin
                    m_req   = 1'b1;
                    m_we    = 1'b1;
                    m_wdata = d_wdata;
                    if (m_ack) state_next = RSP;
                    else       cnt_inc    = 1'b1;
                end
            end
            RSP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op       <= MEM_OP_LOAD;
            sel_d    <= 1'b0;
            last_d   <= 1'b0;
            addr_q   <= '0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                sel_d  <= arb_d;
                last_d <= arb_d;
                op     <= (arb_d && d_we) ? MEM_OP_STORE : MEM_OP_LOAD;
                addr_q <= arb_d ? d_addr[31:2] : if_addr[31:2];
                err_q  <= 1'b0;
            end
            if (cnt_clr)      wait_cnt <= '0;
            else if (cnt_inc) wait_cnt <= wait_cnt + 1'b1;
            if (err_set) err_q <= 1'b1;
            if (rd_latch) begin
                if (sel_d) d_rdata  <= m_rdata;
                else       if_rdata <= m_rdata;
            end
        end
    end

    assign m_addr   = {addr_q, 2'b00};
    assign if_ready = (state == RSP) & ~sel_d;
    assign d_ready  = (state == RSP) &  sel_d;
    assign d_err    = (state == RSP) &  err_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Randomized self-checking bench for mem_sequencer against a memory/transaction model.
module tb_mem_sequencer;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_ready, d_req, d_we, d_fault, d_ready, d_err;
    logic        m_req, m_we, m_ack;
    logic [31:0] if_addr, if_rdata, d_addr, d_rdata, d_wdata;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    int          mode = 0;      // 0 normal, 1 never ack, 2 ack reads only
    int          max_wait = 0;
    int          waits_q[$];
    int          w_left = 0;
    bit          busy = 0;
    logic [31:0] st_val = '0;
    logic [31:0] st_mask = '0;

    always #5 clk = ~clk;

    // load/store unit merge: combinational from the registered read word
    assign d_wdata = (d_rdata & ~st_mask) | (st_val & st_mask);

    mem_sequencer #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_rdata(d_rdata),
        .d_wdata(d_wdata), .d_fault(d_fault), .d_ready(d_ready), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    // memory responder: picks a wait per phase, acks for one cycle
    initial begin
        m_ack   = 1'b0;
        m_rdata = '0;
        forever begin
            @(negedge clk);
            if (m_req && rst_n) begin
                if (!busy) begin
                    busy = 1;
                    if (mode == 1 || (mode == 2 && m_we)) w_left = 1000000;
                    else w_left = $urandom_range(0, max_wait);
                    waits_q.push_back(w_left);
                end
                if (w_left == 0) begin
                    m_ack = 1'b1;
                    if (m_we) mem[m_addr[9:2]] = m_wdata;
                    else      m_rdata = mem[m_addr[9:2]];
                    busy = 0;
                end else begin
                    m_ack = 1'b0;
                    w_left--;
                end
            end else begin
                m_ack = 1'b0;
                busy  = 0;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        if_req = 0; d_req = 0; d_we = 0; d_fault = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_req = 0; d_req = 0; d_we = 0; d_fault = 0;
        if_addr = '0; d_addr = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({m_req, m_we, if_ready, d_ready, d_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {m_req, m_we, if_ready, d_ready, d_err});
        end
        checks++;
        if (if_rdata !== 32'h0 || d_rdata !== 32'h0 || m_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: if_rdata=%h d_rdata=%h m_wdata=%h expected 0", if_rdata, d_rdata, m_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (m_req !== 1'b0 || if_ready !== 1'b0 || d_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: m_req=%b if_ready=%b d_ready=%b expected 0", m_req, if_ready, d_ready);
        end
    endtask

    task automatic data_txn(input bit we, input logic [31:0] addr, input bit fault,
                            input logic [31:0] val, input logic [31:0] mask, input int mw);
        int n, mwe, lat;
        bit seen, done;
        logic [7:0]  wi;
        logic [31:0] exp_rd;
        mode = 0; max_wait = mw; waits_q.delete();
        wi = addr[9:2];
        exp_rd = ref_mem[wi];
        st_val = val; st_mask = we ? mask : 32'h0;
        @(negedge clk);
        d_req = 1; d_we = we; d_addr = addr; d_fault = fault;
        n = 0; mwe = 0; seen = 0; done = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            if (m_req && m_we) mwe++;
            if (m_req && !seen) begin
                seen = 1;
                checks++;
                if (m_addr !== (addr & ~32'd3)) begin
                    errors++;
                    $display("FAIL d_m_addr: got %h expected %h", m_addr, addr & ~32'd3);
                end
            end
            if (if_ready) begin
                checks++; errors++;
                $display("FAIL spurious_if_ready: got 1 expected 0");
            end
            if (d_ready) begin
                done = 1;
                d_req = 0; d_fault = 0;
                lat = 2 + ((waits_q.size() > 0) ? waits_q[0] : 0);
                if (we) lat += 1 + ((!fault && waits_q.size() > 1) ? waits_q[1] : 0);
                checks++;
                if (n != lat) begin
                    errors++;
                    $display("FAIL d_latency: got %0d expected %0d (we=%0d fault=%0d)", n, lat, we, fault);
                end
                checks++;
                if (d_rdata !== exp_rd) begin
                    errors++;
                    $display("FAIL d_rdata: got %h expected %h", d_rdata, exp_rd);
                end
                checks++;
                if (d_err !== fault) begin
                    errors++;
                    $display("FAIL d_err: got %b expected %b", d_err, fault);
                end
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL d_ready_timeout: got no d_ready expected one within 60 cycles");
            d_req = 0; d_fault = 0;
        end
        if (we && !fault) ref_mem[wi] = (ref_mem[wi] & ~mask) | (val & mask);
        checks++;
        if (we && !fault) begin
            if (waits_q.size() != 2 || mwe != 1 + waits_q[1]) begin
                errors++;
                $display("FAIL m_we_cycles: got %0d expected write phase of %0d", mwe, (waits_q.size() > 1) ? 1 + waits_q[1] : 1);
            end
        end else if (mwe != 0) begin
            errors++;
            $display("FAIL m_we_cycles: got %0d expected 0", mwe);
        end
        checks++;
        if (mem[wi] !== ref_mem[wi]) begin
            errors++;
            $display("FAIL mem_word: got %h expected %h at word %0d", mem[wi], ref_mem[wi], wi);
        end
    endtask

    task automatic fetch_txn(input logic [31:0] addr, input int mw);
        int n;
        bit done;
        logic [31:0] exp_rd;
        mode = 0; max_wait = mw; waits_q.delete();
        exp_rd = ref_mem[addr[9:2]];
        @(negedge clk);
        if_req = 1; if_addr = addr;
        n = 0; done = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            if (d_ready) begin
                checks++; errors++;
                $display("FAIL spurious_d_ready: got 1 expected 0");
            end
            if (if_ready) begin
                done = 1;
                if_req = 0;
                checks++;
                if (n != 2 + ((waits_q.size() > 0) ? waits_q[0] : 0)) begin
                    errors++;
                    $display("FAIL if_latency: got %0d expected %0d", n, 2 + ((waits_q.size() > 0) ? waits_q[0] : 0));
                end
                checks++;
                if (if_rdata !== exp_rd || d_err !== 1'b0) begin
                    errors++;
                    $display("FAIL if_rdata: got %h err=%b expected %h err=0", if_rdata, d_err, exp_rd);
                end
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL if_ready_timeout: got no if_ready expected one within 60 cycles");
            if_req = 0;
        end
    endtask

    task automatic test_timeout(input bit fetch, input bit we);
        int n, req_cycles, mwe;
        bit done, got_d;
        mode = 1;
        st_mask = 32'h0;
        @(negedge clk);
        if (fetch) begin if_req = 1; if_addr = 32'h40; end
        else begin d_req = 1; d_we = we; d_addr = 32'h80; d_fault = 0; end
        n = 0; req_cycles = 0; mwe = 0; done = 0; got_d = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (m_req) req_cycles++;
            if (m_req && m_we) mwe++;
            if (if_ready || d_ready) begin
                done = 1;
                got_d = d_ready;
                checks++;
                if (d_err !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_err: got %b expected 1", d_err);
                end
            end
        end
        if_req = 0; d_req = 0;
        checks++;
        if (!done || got_d !== !fetch) begin
            errors++;
            $display("FAIL timeout_ready: got done=%0d data=%0d expected done=1 data=%0d", done, got_d, !fetch);
        end
        checks++;
        if (req_cycles != TO || mwe != 0) begin
            errors++;
            $display("FAIL timeout_m_req: got %0d req cycles, %0d write cycles expected %0d and 0", req_cycles, mwe, TO);
        end
        mode = 0;
    endtask

    task automatic test_reset_mid_wr();
        int n;
        bit in_wr;
        logic [7:0] wi;
        wi = 8'd20;
        mode = 2; waits_q.delete();
        st_val = 32'hCAFEF00D; st_mask = 32'hFFFFFFFF;
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = {22'h0, wi, 2'b00}; d_fault = 0;
        n = 0; in_wr = 0;
        while (!in_wr && n < 30) begin
            @(negedge clk);
            n++;
            if (m_req && m_we) in_wr = 1;
        end
        checks++;
        if (!in_wr) begin
            errors++;
            $display("FAIL reset_wr_reach: got no write phase expected one");
        end
        rst_n = 0; d_req = 0;
        #1;
        checks++;
        if (m_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_wr_m_req: got %b expected 0", m_req);
        end
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) @(negedge clk);
            else begin
                rst_n = 1;
                @(negedge clk);
            end
            if (d_ready || if_ready) n++;
        end
        checks++;
        if (n != 0 || mem[wi] !== ref_mem[wi]) begin
            errors++;
            $display("FAIL reset_wr_effect: got %0d ready pulses mem=%h expected 0 and %h", n, mem[wi], ref_mem[wi]);
        end
        mode = 0;
        data_txn(0, {22'h0, wi, 2'b00}, 0, 32'h0, 32'h0, 1);
    endtask

    task automatic test_contention();
        int grants, n;
        bit last_d, exp_d, who;
        logic [31:0] fa, da, cur;
        do_reset();
        mode = 0; max_wait = 2; st_mask = 32'h0;
        last_d = 0;
        fa = {22'h0, 8'($urandom), 2'b00};
        da = {22'h0, 8'($urandom), 2'b00};
        @(negedge clk);
        if_req = 1; if_addr = fa; d_req = 1; d_we = 0; d_addr = da; d_fault = 0;
        grants = 0; n = 0;
        while (grants < 4 && n < 100) begin
            @(negedge clk);
            n++;
            if (d_ready || if_ready) begin
                who = d_ready;
                exp_d = !last_d;
                cur = who ? da : fa;
                checks++;
                if (who !== exp_d) begin
                    errors++;
                    $display("FAIL contention_order: grant %0d got %s expected %s", grants, who ? "D" : "F", exp_d ? "D" : "F");
                end
                checks++;
                if ((who ? d_rdata : if_rdata) !== ref_mem[cur[9:2]]) begin
                    errors++;
                    $display("FAIL contention_rdata: got %h expected %h", who ? d_rdata : if_rdata, ref_mem[cur[9:2]]);
                end
                last_d = who;
                grants++;
                if (who) begin da = {22'h0, 8'($urandom), 2'b00}; d_addr = da; end
                else     begin fa = {22'h0, 8'($urandom), 2'b00}; if_addr = fa; end
            end
        end
        if_req = 0; d_req = 0;
        checks++;
        if (grants != 4) begin
            errors++;
            $display("FAIL contention_count: got %0d grants expected 4", grants);
        end
    endtask

    task automatic test_random();
        int kind, b;
        logic [31:0] a, msk;
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 2);
            a = {22'h0, 10'($urandom)};
            if (kind == 0) fetch_txn(a, 2);
            else begin
                b = $urandom_range(0, 3);
                msk = 32'hFF << (8 * b);
                data_txn(kind == 2, a, $urandom_range(0, 4) == 0, $urandom, msk, 2);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[8'h41] = 32'hDEADBEEF; ref_mem[8'h41] = 32'hDEADBEEF;
        mem[8'h40] = 32'h11223344; ref_mem[8'h40] = 32'h11223344;
        test_reset();
        data_txn(0, 32'h104, 0, 32'h0, 32'h0, 0);
        data_txn(1, 32'h101, 0, 32'h0000AA00, 32'h0000FF00, 0);
        checks++;
        if (mem[8'h40] !== 32'h1122AA44) begin
            errors++;
            $display("FAIL byte_store: got %h expected 1122aa44", mem[8'h40]);
        end
        data_txn(1, 32'h203, 1, 32'h55000000, 32'hFF000000, 0);
        data_txn(0, 32'h206, 1, 32'h0, 32'h0, 1);
        fetch_txn(32'h104, 0);
        test_contention();
        test_timeout(0, 0);
        test_timeout(0, 1);
        test_timeout(1, 0);
        test_reset_mid_wr();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
